// File: rtl/procesador_program_loader.sv
// Program loader: packs a byte stream into little-endian 32-bit words, writes each one
// over Avalon-MM, reads it back to verify, and holds the CPU in reset while it runs.
module procesador_program_loader #(
  parameter int ADDR_W       = 15,
  parameter int DEPTH        = 32768,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic              m_read,
  input  logic [31:0]       m_readdata,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr,
  output logic              cpu_reset_req
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_WAIT    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]      LAT_LAST = 2'(READ_LATENCY - 1);

  state_t              state_r, state_s;
  logic [ADDR_W:0]     count_r;
  logic [ADDR_W-1:0]   addr_r, err_addr_r;
  logic [1:0]          byte_idx_r, lat_cnt_r;
  logic [31:0]         wdata_r;
  logic                error_r;
  logic                s_ready_r, m_write_r, m_read_r, m_chipselect_r, busy_r, done_r;
  logic [3:0]          m_byteenable_r;
  logic                s_ready_s, m_write_s, m_read_s, m_chipselect_s, busy_s, done_s;
  logic [3:0]          m_byteenable_s;
  logic                hs_s, lat_done_s, match_s, last_s, zero_s, oversize_s;

  assign hs_s       = s_valid & s_ready_r;
  assign lat_done_s = (lat_cnt_r == LAT_LAST);
  assign match_s    = (m_readdata == wdata_r);
  assign last_s     = (({1'b0, addr_r} + (ADDR_W + 1)'(1)) == count_r);
  assign zero_s     = (word_count == {(ADDR_W + 1){1'b0}});
  assign oversize_s = (word_count > DEPTH_W);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Next-state decode plus the Moore outputs of the state being entered.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (zero_s || oversize_s) state_s = ST_DONE;
          else                      state_s = ST_COLLECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (hs_s && (byte_idx_r == 2'd3)) state_s = ST_WRITE;
        else                              state_s = ST_COLLECT;
      end
      ST_WRITE: begin
        if (!m_waitrequest) state_s = ST_READ;
        else                state_s = ST_WRITE;
      end
      ST_READ: begin
        if (!m_waitrequest) state_s = ST_WAIT;
        else                state_s = ST_READ;
      end
      ST_WAIT: begin
        if (!lat_done_s)            state_s = ST_WAIT;
        else if (!match_s || last_s) state_s = ST_DONE;
        else                        state_s = ST_COLLECT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase

    s_ready_s      = (state_s == ST_COLLECT);
    m_write_s      = (state_s == ST_WRITE);
    m_read_s       = (state_s == ST_READ);
    m_chipselect_s = m_write_s | m_read_s;
    m_byteenable_s = m_chipselect_s ? 4'hF : 4'h0;
    busy_s         = (state_s == ST_COLLECT) || (state_s == ST_WRITE) ||
                     (state_s == ST_READ)    || (state_s == ST_WAIT);
    done_s         = (state_s == ST_DONE);
  end

  // Output registers; decoding the next state keeps them aligned with state_r.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ready_r      <= 1'b0;
      m_write_r      <= 1'b0;
      m_read_r       <= 1'b0;
      m_chipselect_r <= 1'b0;
      m_byteenable_r <= 4'h0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      s_ready_r      <= s_ready_s;
      m_write_r      <= m_write_s;
      m_read_r       <= m_read_s;
      m_chipselect_r <= m_chipselect_s;
      m_byteenable_r <= m_byteenable_s;
      busy_r         <= busy_s;
      done_r         <= done_s;
    end
  end

  // Datapath: word count, address, byte assembly, latency counter and verdict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r    <= {(ADDR_W + 1){1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      err_addr_r <= {ADDR_W{1'b0}};
      byte_idx_r <= 2'd0;
      lat_cnt_r  <= 2'd0;
      wdata_r    <= 32'h0000_0000;
      error_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            count_r    <= word_count;
            addr_r     <= {ADDR_W{1'b0}};
            byte_idx_r <= 2'd0;
            err_addr_r <= {ADDR_W{1'b0}};
            error_r    <= oversize_s;
          end
        end
        ST_COLLECT: begin
          if (hs_s) begin
            wdata_r[{byte_idx_r, 3'b000} +: 8] <= s_data;
            byte_idx_r                         <= byte_idx_r + 2'd1;
          end
        end
        ST_READ: lat_cnt_r <= 2'd0;
        ST_WAIT: begin
          if (!lat_done_s) begin
            lat_cnt_r <= lat_cnt_r + 2'd1;
          end else if (!match_s) begin
            error_r    <= 1'b1;
            err_addr_r <= addr_r;
          end else if (!last_s) begin
            addr_r     <= addr_r + ADDR_W'(1);
            byte_idx_r <= 2'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s_ready       = s_ready_r;
  assign m_address     = addr_r;
  assign m_byteenable  = m_byteenable_r;
  assign m_chipselect  = m_chipselect_r;
  assign m_write       = m_write_r;
  assign m_writedata   = wdata_r;
  assign m_read        = m_read_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;
  assign err_addr      = err_addr_r;
  assign cpu_reset_req = busy_r;

endmodule

// File: doc/procesador_program_loader.md
# procesador_program_loader

Avalon-MM master that loads and verifies the processor's 32-bit program memory from a byte stream, e.g. a host link. It assembles four bytes into each little-endian word and writes it to the next word address. It then reads the word back, compares it, and reports completion or the first mismatching address. While it runs, it holds the processor in reset through `cpu_reset_req`.

## Interface
- `ADDR_W`, 15: word-address width of the target memory.
- `DEPTH`, 32768: number of words in the target memory.
- `READ_LATENCY`, 1: fixed slave read latency in cycles, from read acceptance to valid `m_readdata`. Legal range 1..3.

- `clk`  in  1  single clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle load request; ignored unless the block is idle.
- `word_count`  in  ADDR_W+1  number of words to load; latched when `start` is accepted.
- `s_data`  in  8  stream byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  block accepts a byte this cycle.
- `m_address`  out  ADDR_W  word address.
- `m_byteenable`  out  4  always 4'hF during an access.
- `m_chipselect`  out  1  asserted with `m_write` or `m_read`.
- `m_write`  out  1  write request.
- `m_writedata`  out  32  assembled word.
- `m_read`  out  1  read request.
- `m_readdata`  in  32  read data.
- `m_waitrequest`  in  1  slave stall; tie to 0 for the on-chip memory.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse when a load ends, whether it passed or failed.
- `error`  out  1  sticky failure flag; cleared by the next accepted `start`.
- `err_addr`  out  ADDR_W  address of the first mismatch; valid while `error`=1.
- `cpu_reset_req`  out  1  equal to `busy`.

## Operation
- FSM states: IDLE, COLLECT, WRITE, READ, WAIT, DONE.
- IDLE:
  - `start`=1 latches `word_count`, clears `error`, `err_addr`, the address counter and the byte index.
  - `word_count`=0 goes to DONE with no bus access.
  - `word_count`>DEPTH sets `error`, loads `err_addr`=0 and goes to DONE with no bus access.
  - Any other value goes to COLLECT.
- COLLECT:
  - `s_ready`=1.
  - Each handshake (`s_valid`&`s_ready`) stores byte k (k=0..3) into `m_writedata[8k+7:8k]`.
  - The 4th byte moves the FSM to WRITE.
- WRITE:
  - `m_write`=`m_chipselect`=1; address, data and `m_byteenable` are held stable.
  - Stays in WRITE while `m_waitrequest`=1, then moves to READ.
- READ:
  - `m_read`=`m_chipselect`=1 at the same address.
  - Stays in READ while `m_waitrequest`=1, then moves to WAIT.
- WAIT:
  - Counts READ_LATENCY cycles after the read is accepted, then samples `m_readdata` and compares it with `m_writedata`.
  - Mismatch: `error`=1, `err_addr`=current address, go to DONE.
  - Match on the last word (address = count−1): go to DONE.
  - Match otherwise: address+1, byte index 0, go to COLLECT.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `busy`=1 in COLLECT, WRITE, READ and WAIT; 0 in IDLE and DONE.
- `start` while `busy`=1 is ignored, with no state change.
- No stream bytes are consumed outside COLLECT. Bytes remaining after an aborted load are the upstream's responsibility.
- The address counter never wraps: the last address is count−1 ≤ DEPTH−1.

## Timing
- Reset values: all outputs 0, state IDLE, `m_writedata`=0, `err_addr`=0.
- `reset_n` low mid-load aborts immediately and asynchronously: no `done` pulse, and `m_write`/`m_read` drop at once.
- Every other output is registered.
- Start to first `s_ready`: 1 cycle (the COLLECT state begins on the edge that samples `start`).
- Per word, with continuous `s_valid` and `m_waitrequest`=0: 4 + 1 + 1 + READ_LATENCY cycles (7 with the defaults).
- Each `m_waitrequest` cycle adds one cycle.
- `done` rises on the cycle after the final compare edge, or on the cycle after `start` for the 0/oversize cases.
- `s_valid` gaps stall COLLECT with no timeout.

## Test plan
- Load 2 words from bytes 11 22 33 44 55 66 77 88, with an ideal memory model and `m_waitrequest`=0:
  - writes 0x44332211 @0 and 0x88776655 @1;
  - each write is read back;
  - `done` arrives 14 cycles after the first byte; `error`=0.
- Same load with `m_waitrequest` high for 3 cycles on each write and read: identical data, 12 extra cycles, and all outputs stable while stalled.
- Model corrupts bit 0 of word 1: `error`=1, `err_addr`=1, `done` pulse, no further bus access; `cpu_reset_req` falls with `busy`.
- Start with `word_count`=0: `done` on the next cycle, no bus access. Start with DEPTH+1: `error`=1, `err_addr`=0.
- Assert `reset_n` low during WRITE of word 3 of 5: outputs 0 immediately; a new start then loads correctly from address 0.
- Pulse `start` again mid-load and run READ_LATENCY=2: the extra `start` is ignored, and the compare uses data sampled 2 cycles after read acceptance.
